// File: rtl/program_loader.sv
// program_loader: streams a program image into instruction memory, reads it back
// against a running checksum, and only then releases the core.
module program_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  input  logic [DATA_W-1:0] word_in,
  input  logic              word_valid,
  input  logic              word_last,
  output logic              word_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_q,
  output logic              core_start,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   word_count
);
  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, CHECK, RUN, ERR} state_t;
  state_t r_state, w_next;
  logic [DATA_W-1:0] r_checksum, r_vsum;
  logic [ADDR_W:0]   r_rd_idx;
  logic [RD_LAT-1:0] r_vld;
  logic w_acc, w_rd, w_vdone, w_start, w_top;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = load_req ? LOAD : IDLE;
      LOAD:    w_next = !w_acc ? LOAD : word_last ? VERIFY : w_top ? ERR : LOAD;
      VERIFY:  w_next = w_vdone ? CHECK : VERIFY;
      CHECK:   w_next = (r_vsum == r_checksum) ? RUN : ERR;
      default: w_next = load_req ? LOAD : r_state;
    endcase
  end
  always_comb begin
    word_ready = r_state == LOAD;
    w_acc      = word_ready && word_valid;
    w_top      = word_count == {1'b0, {ADDR_W{1'b1}}};
    w_rd       = r_state == VERIFY && r_rd_idx < word_count;
    w_vdone    = r_state == VERIFY && r_rd_idx == word_count && !mem_rden && r_vld == '0;
    w_start    = load_req && (r_state == IDLE || r_state == RUN || r_state == ERR);
  end
  // Readback samples are tagged by a valid shift register so q is summed exactly RD_LAT cycles after rden.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      mem_addr   <= '0;
      mem_data   <= '0;
      mem_wren   <= 1'b0;
      mem_rden   <= 1'b0;
      core_start <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'b00;
      word_count <= '0;
      r_checksum <= '0;
      r_vsum     <= '0;
      r_rd_idx   <= '0;
      r_vld      <= '0;
    end else begin
      mem_wren <= w_acc;
      mem_rden <= w_rd;
      r_vld    <= (r_vld << 1) | RD_LAT'(mem_rden);
      if (r_vld[RD_LAT-1]) r_vsum <= r_vsum + mem_q;
      if (w_acc) begin
        mem_addr   <= word_count[ADDR_W-1:0];
        mem_data   <= word_in;
        word_count <= word_count + (ADDR_W+1)'(1);
        r_checksum <= r_checksum + word_in;
      end
      if (w_rd) begin
        mem_addr <= r_rd_idx[ADDR_W-1:0];
        r_rd_idx <= r_rd_idx + (ADDR_W+1)'(1);
      end
      if (w_start) begin
        core_start <= 1'b0;
        done       <= 1'b0;
        error      <= 1'b0;
        err_code   <= 2'b00;
        word_count <= '0;
        r_checksum <= '0;
        r_vsum     <= '0;
        r_rd_idx   <= '0;
      end
      if (r_state == LOAD && w_next == ERR) begin
        error    <= 1'b1;
        err_code <= 2'b01;
      end
      if (r_state == CHECK && w_next == RUN) begin
        core_start <= 1'b1;
        done       <= 1'b1;
      end
      if (r_state == CHECK && w_next == ERR) begin
        error    <= 1'b1;
        err_code <= 2'b10;
      end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed scenarios for program_loader with a behavioural RD_LAT=2 memory.
module tb_program_loader;
  logic clk = 0, rst = 1;
  logic load_req = 0, word_valid = 0, word_last = 0;
  logic [15:0] word_in = 0, mem_q, mem_data;
  logic [8:0] mem_addr;
  logic [9:0] word_count;
  logic [1:0] err_code;
  logic word_ready, mem_wren, mem_rden, core_start, done, error;
  int n_chk = 0, n_fail = 0;
  program_loader dut (
    .clock(clk), .reset(rst), .load_req(load_req), .word_in(word_in),
    .word_valid(word_valid), .word_last(word_last), .word_ready(word_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .mem_q(mem_q), .core_start(core_start), .done(done), .error(error),
    .err_code(err_code), .word_count(word_count)
  );
  always #5 clk = ~clk;
  logic [15:0] mem [512];
  logic [15:0] p0 = 0, p1 = 0;
  logic corrupt = 0;
  always @(posedge clk) begin
    if (mem_wren) mem[mem_addr] <= mem_data;
    if (mem_rden) p0 <= (corrupt && mem_addr == 9'd2) ? mem[mem_addr] + 16'd1 : mem[mem_addr];
    p1 <= p0;
  end
  assign mem_q = p1;
  int cyc = 0, nw = 0, nr = 0, na = 0, both = 0;
  int wa [600], wd [600], wcy [600], acy [600], ra [600];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (word_valid && word_ready) begin acy[na] = cyc; na = na + 1; end
    if (mem_wren) begin wa[nw] = int'(mem_addr); wd[nw] = int'(mem_data); wcy[nw] = cyc; nw = nw + 1; end
    if (mem_rden) begin ra[nr] = int'(mem_addr); nr = nr + 1; end
    if (mem_wren && mem_rden) both = both + 1;
  end
  task automatic clear_logs();
    nw = 0; nr = 0; na = 0; both = 0;
  endtask
  task automatic pulse_load();
    @(posedge clk); #1 load_req = 1;
    @(posedge clk); #1 load_req = 0;
  endtask
  task automatic send_word(input logic [15:0] w, input logic last, input logic gap);
    if (gap) begin @(posedge clk); #1; end
    word_in = w; word_last = last; word_valid = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (word_ready) break;
      if (i == 19) begin n_chk++; n_fail++; $display("FAIL ready_timeout got=%b want=1", word_ready); end
    end
    @(posedge clk); #1 word_valid = 0; word_last = 0;
  endtask
  task automatic wait_end();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done || error) break;
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic check_writes(input string nm, input int exp_n, input logic [15:0] d [4]);
    int bad = 0;
    n_chk++;
    if (nw !== exp_n) begin n_fail++; $display("FAIL %s_nwrites got=%0d want=%0d", nm, nw, exp_n); end
    for (int i = 0; i < exp_n && i < nw; i++)
      if (wa[i] != i || wd[i] != int'(d[i]) || wcy[i] != acy[i] + 1 || (i > 0 && wcy[i] != wcy[i-1] + 1 && nm == "s1")) bad++;
    n_chk++;
    if (bad !== 0) begin n_fail++; $display("FAIL %s_write_seq got=%0d bad want=0", nm, bad); end
    bad = 0;
    for (int i = 0; i < nr; i++) if (ra[i] != i) bad++;
    n_chk++;
    if (nr !== exp_n || bad !== 0) begin n_fail++; $display("FAIL %s_reads got=%0d/%0d bad want=%0d/0", nm, nr, bad, exp_n); end
    n_chk++;
    if (both !== 0) begin n_fail++; $display("FAIL %s_wren_rden_overlap got=%0d want=0", nm, both); end
  endtask
  task automatic check_result(input string nm, input logic d, input logic cs, input logic e, input logic [1:0] ec, input logic [9:0] wc);
    n_chk++;
    if ({done, core_start, error, err_code, word_count} !== {d, cs, e, ec, wc}) begin
      n_fail++;
      $display("FAIL %s_result got done=%b start=%b err=%b code=%b wc=%0d want done=%b start=%b err=%b code=%b wc=%0d",
               nm, done, core_start, error, err_code, word_count, d, cs, e, ec, wc);
    end
  endtask
  task automatic test_reset();
    #2;
    n_chk++;
    if ({word_ready, mem_addr, mem_data, mem_wren, mem_rden, core_start, done, error, err_code, word_count} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got nonzero want all 0");
    end
    @(negedge clk); rst = 0;
  endtask
  task automatic test_basic(input string nm, input logic gap);
    logic [15:0] d [4] = '{16'd3, 16'd7, 16'd11, 16'hFFFF};
    clear_logs();
    pulse_load();
    for (int i = 0; i < 4; i++) send_word(d[i], i == 3, gap);
    wait_end();
    check_writes(nm, 4, d);
    check_result(nm, 1, 1, 0, 2'b00, 10'd4);
  endtask
  task automatic test_reload();
    logic [15:0] d [4] = '{16'h1234, 16'd0, 16'd0, 16'd0};
    clear_logs();
    @(posedge clk); #1 load_req = 1;
    @(posedge clk); #1 load_req = 0;
    n_chk++;
    if (core_start !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reload_start_drop got=%b%b want=00", core_start, done); end
    send_word(16'h1234, 1, 0);
    wait_end();
    check_writes("s5", 1, d);
    check_result("s5", 1, 1, 0, 2'b00, 10'd1);
  endtask
  task automatic test_checksum_err();
    logic [15:0] d [4] = '{16'd3, 16'd7, 16'd11, 16'hFFFF};
    corrupt = 1;
    clear_logs();
    pulse_load();
    for (int i = 0; i < 4; i++) send_word(d[i], i == 3, 0);
    wait_end();
    corrupt = 0;
    check_writes("s3", 4, d);
    check_result("s3", 0, 0, 1, 2'b10, 10'd4);
  endtask
  task automatic test_overflow();
    int bad = 0;
    clear_logs();
    pulse_load();
    for (int i = 0; i < 512; i++) send_word(16'(i * 3), 0, 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < nw; i++) if (wa[i] != i || wd[i] != int'(16'(i * 3))) bad++;
    n_chk++;
    if (nw !== 512 || bad !== 0 || wa[511] !== 511) begin n_fail++; $display("FAIL s4_writes got=%0d/%0d bad want=512/0", nw, bad); end
    n_chk++;
    if (nr !== 0) begin n_fail++; $display("FAIL s4_no_reads got=%0d want=0", nr); end
    n_chk++;
    if (word_ready !== 1'b0) begin n_fail++; $display("FAIL s4_ready_low got=%b want=0", word_ready); end
    check_result("s4", 0, 0, 1, 2'b01, 10'd512);
  endtask
  task automatic test_reset_midload();
    logic [15:0] d [4] = '{16'hBEEF, 16'd0, 16'd0, 16'd0};
    clear_logs();
    pulse_load();
    send_word(16'h0AAA, 0, 0);
    send_word(16'h0BBB, 0, 0);
    #2 rst = 1;
    #1;
    n_chk++;
    if ({word_ready, mem_addr, mem_data, mem_wren, mem_rden, core_start, done, error, err_code, word_count} !== '0) begin
      n_fail++; $display("FAIL s6_async_reset got nonzero want all 0 (wc=%0d addr=%0d)", word_count, mem_addr);
    end
    @(negedge clk); rst = 0;
    clear_logs();
    pulse_load();
    send_word(16'hBEEF, 1, 0);
    wait_end();
    check_writes("s6", 1, d);
    check_result("s6", 1, 1, 0, 2'b00, 10'd1);
  endtask
  initial begin
    test_reset();
    test_basic("s1", 0);
    test_reload();
    test_basic("s2", 1);
    test_checksum_err();
    test_overflow();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
